// File: rtl/serv_shift_mac_seq.sv
// serv_shift_mac_seq: sequences the serial buffer through init, mac, wait, run and done passes
module serv_shift_mac_seq #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int WD_LIMIT = 64,
  localparam int P = 32 / BITS_PER_CYCLE,
  localparam int CW = (P > 1) ? $clog2(P) : 1,
  localparam int WW = $clog2(WD_LIMIT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_abort,
  input  logic          i_sh_done,
  output logic          o_init,
  output logic          o_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_cnt_done,
  output logic          o_shift_op,
  output logic          o_right_shift_op,
  output logic          o_mac_step1,
  output logic          o_mac_step2,
  output logic          o_rd_en,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT, MAC2, RUN, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic err;
  logic pass;
  logic last;
  logic shift;
  assign pass = state inside {INIT, MAC2, RUN};
  assign last = pass && cnt == CW'(P - 1);
  assign shift = state inside {INIT, WAIT, RUN} && op != 2'd2;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      wd <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      cnt <= (pass && !last) ? cnt + CW'(1) : '0;
      wd <= (state == WAIT) ? wd + WW'(1) : '0;
      if (i_abort && state != IDLE) begin
        state <= IDLE;
        cnt <= '0;
        wd <= '0;
      end else begin
        case (state)
          IDLE: if (i_start && i_op != 2'd3) begin
            state <= INIT;
            op <= i_op;
          end
          INIT: if (last) state <= (op == 2'd2) ? MAC2 : WAIT;
          WAIT: if (i_sh_done) state <= RUN;
          else if (wd == WW'(WD_LIMIT - 1)) begin
            state <= IDLE;
            err <= 1'b1;
          end
          MAC2: if (last) state <= RUN;
          RUN: if (last) state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign o_init = state inside {INIT, MAC2};
  assign o_en = pass;
  assign o_cnt = cnt;
  assign o_cnt_done = last;
  assign o_shift_op = shift;
  assign o_right_shift_op = shift && op == 2'd1;
  assign o_mac_step1 = state == INIT && op == 2'd2;
  assign o_mac_step2 = state == MAC2;
  assign o_rd_en = state == RUN;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_err = err;
endmodule

// File: tb/tb_serv_shift_mac_seq.sv
// tb_serv_shift_mac_seq: scoreboard bench driving a P=8 and a P=32 sequencer from shared inputs
module tb_serv_shift_mac_seq;
  localparam int WD = 64;
  localparam int P4 = 8;
  typedef struct {bit err; int at;} exp_t;
  logic i_clk, i_rst, i_start, i_abort, i_sh_done;
  logic [1:0] i_op;
  logic init4, en4, cd4, sh4, rs4, m14, m24, rd4, bz4, dn4, er4;
  logic [2:0] cnt4;
  logic init1, en1, cd1, sh1, rs1, m11, m21, rd1, bz1, dn1, er1;
  logic [4:0] cnt1;
  logic [15:0] v4, v1;
  int ec = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t e;
  serv_shift_mac_seq #(.BITS_PER_CYCLE(4), .WD_LIMIT(WD)) u4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_abort(i_abort),
    .i_sh_done(i_sh_done), .o_init(init4), .o_en(en4), .o_cnt(cnt4), .o_cnt_done(cd4),
    .o_shift_op(sh4), .o_right_shift_op(rs4), .o_mac_step1(m14), .o_mac_step2(m24),
    .o_rd_en(rd4), .o_busy(bz4), .o_done(dn4), .o_err(er4)
  );
  serv_shift_mac_seq #(.BITS_PER_CYCLE(1), .WD_LIMIT(WD)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_abort(i_abort),
    .i_sh_done(i_sh_done), .o_init(init1), .o_en(en1), .o_cnt(cnt1), .o_cnt_done(cd1),
    .o_shift_op(sh1), .o_right_shift_op(rs1), .o_mac_step1(m11), .o_mac_step2(m21),
    .o_rd_en(rd1), .o_busy(bz1), .o_done(dn1), .o_err(er1)
  );
  assign v4 = {er4, dn4, bz4, init4, en4, sh4, rs4, m14, m24, rd4, cd4, 2'b00, cnt4};
  assign v1 = {er1, dn1, bz1, init1, en1, sh1, rs1, m11, m21, rd1, cd1, cnt1};
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) ec <= ec + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ec);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  function automatic logic [15:0] ev(int p, int op, int w, int r);
    bit er = 0, dn = 0, bz = 0, ini = 0, en = 0, sh = 0, m1 = 0, m2 = 0, rd = 0, cd = 0;
    int c = 0;
    int wt = (w == 0) ? WD : w;
    if (op == 2) begin
      if (r >= 1 && r <= 3 * p) begin
        bz = 1; en = 1; c = (r - 1) % p;
        ini = r <= 2 * p; m1 = r <= p; m2 = r > p && r <= 2 * p; rd = r > 2 * p;
      end else if (r == 3 * p + 1) begin
        bz = 1; dn = 1;
      end
    end else if (op != 3 && r >= 1) begin
      if (r <= p) begin
        bz = 1; ini = 1; en = 1; sh = 1; c = r - 1;
      end else if (r <= p + wt) begin
        bz = 1; sh = 1;
      end else if (w == 0) begin
        er = r == p + wt + 1;
      end else if (r <= 2 * p + wt) begin
        bz = 1; en = 1; rd = 1; sh = 1; c = r - p - wt - 1;
      end else if (r == 2 * p + wt + 1) begin
        bz = 1; dn = 1;
      end
    end
    cd = (ini || rd) && c == p - 1;
    return {er, dn, bz, ini, en, sh, sh && op == 1, m1, m2, rd, cd, 5'(c)};
  endfunction
  task automatic run(input string tag, input int op, input int w, input bit hold, input bit both);
    int k, n;
    exp_t x;
    k = ec + 1;
    n = (op == 3) ? 4 : (op == 2) ? 3 * P4 + 2 : (w == 0) ? P4 + WD + 2 : 2 * P4 + w + 2;
    if (both) n = 3 * 32 + 2;
    if (op == 2) x = '{1'b0, k + 3 * P4};
    else if (w == 0) x = '{1'b1, k + P4 + WD};
    else x = '{1'b0, k + 2 * P4 + w};
    if (op != 3) q.push_back(x);
    i_op = 2'(op);
    i_start = 1'b1;
    i_sh_done = 1'b0;
    for (int r = 1; r <= n; r++) begin
      tick;
      chk({tag, "_p8"}, v4, ev(P4, op, w, r));
      if (both) chk({tag, "_p32"}, v1, ev(32, op, w, r));
      i_start = hold && r < n;
      i_sh_done = w > 0 && (r == P4 + w || r == 2);
    end
    i_start = 1'b0;
    i_sh_done = 1'b0;
  endtask
  always @(negedge i_clk) begin
    if (dn4 === 1'b1 || er4 === 1'b1) begin
      if (q.size() == 0) chk("sb_spurious", {er4, dn4}, 2'b00);
      else begin
        e = q.pop_front();
        chk("sb_kind", er4, e.err);
        chk("sb_at", ec, e.at);
      end
    end
  end
  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_op = 2'd0;
    i_abort = 1'b0;
    i_sh_done = 1'b0;
    tick;
    tick;
    chk("rst_p8", v4, 16'h0);
    chk("rst_p32", v1, 16'h0);
    i_rst = 1'b0;
    tick;
    run("mac", 2, 0, 1'b0, 1'b1);
    run("shr_w3", 1, 3, 1'b0, 1'b0);
    run("shl_wd", 0, 0, 1'b0, 1'b0);
    run("shr_tie", 1, WD, 1'b0, 1'b0);
    i_start = 1'b1;
    i_op = 2'd2;
    tick;
    i_start = 1'b0;
    repeat (11) tick;
    chk("in_mac2", m24, 1'b1);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort", v4, 16'h0);
    i_start = 1'b1;
    i_op = 2'd1;
    tick;
    i_start = 1'b0;
    repeat (9) tick;
    i_sh_done = 1'b1;
    tick;
    i_sh_done = 1'b0;
    tick;
    chk("in_run", rd4, 1'b1);
    i_rst = 1'b1;
    i_abort = 1'b1;
    tick;
    i_rst = 1'b0;
    i_abort = 1'b0;
    chk("rst_mid", v4, 16'h0);
    tick;
    run("after", 0, 5, 1'b0, 1'b0);
    run("rsvd", 3, 0, 1'b0, 1'b0);
    run("held", 0, 1, 1'b1, 1'b0);
    run("mac2", 2, 0, 1'b0, 1'b0);
    repeat (3) tick;
    chk("sb_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
